ex_mem_stage: RTL
=================

# ex_mem_stage

Registered hand-off stage between the 16-bit ALU and the data-memory/writeback side of the CPU. It captures each ALU result with its control fields through a two-entry skid buffer, giving full throughput with a registered `in_ready`. It also latches the three-way compare code from `ALUop = 3'b101` into sticky condition flags for the branch logic. Optionally it drives an EX→EX forwarding port.

## Interface
Parameters:
- `DATA_W`, 16: ALU result / store data width
- `REG_W`, 4: destination register address width

Ports:
- `clk`  in  1  the single clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  stage can accept a beat (`state != FULL`)
- `alu_op`  in  3  ALU operation of the beat
- `alu_result`  in  DATA_W  ALU output; memory address for store beats
- `store_data`  in  DATA_W  register value to write for store beats
- `rd_addr`  in  REG_W  destination register
- `reg_write`, `mem_write`, `mem_to_reg`  in  1 each  control fields
- `flush`  in  1  drop all buffered beats
- `out_valid`  out  1  head beat valid
- `out_ready`  in  1  downstream accepts head beat
- `out_alu_result`, `out_store_data`, `out_rd_addr`, `out_reg_write`, `out_mem_write`, `out_mem_to_reg`  out  as inputs  head beat fields
- `flag_eq`, `flag_gt`, `flag_lt`, `flags_valid`  out  1 each  condition flags from the last accepted compare
- `fwd_valid`  out  1  forwarding data available (see Configuration)
- `fwd_rd`  out  REG_W  forwarding register address (see Configuration)
- `fwd_data`  out  DATA_W  forwarding data (see Configuration)

## Operation
- Accept: `acc = in_valid & in_ready & !flush`. Retire: `ret = out_valid & out_ready`.
- States:
  - EMPTY: no beat held.
  - HALF: main register holds the head beat.
  - FULL: main and skid registers both hold beats.
- Transitions:
  - EMPTY: on `acc`, go to HALF.
  - HALF: `acc & !ret` → FULL (beat into skid). `acc & ret` → HALF (main replaced by new beat). `!acc & ret` → EMPTY.
  - FULL: on `ret`, skid moves to main, go to HALF. No accept is possible because `in_ready = 0`.
- `out_valid = (state != EMPTY)`. Output fields always come from the main register.
- `flush` has priority over everything:
  - Next state is EMPTY and the beat offered that cycle is not accepted.
  - Flags are not modified.
  - A `ret` in the same cycle still counts as consumed downstream.
- Flags update on `acc` with `alu_op == 3'b101`, decoded from `alu_result`:
  - 0 → eq=1, gt=0, lt=0, `flags_valid = 1`.
  - 1 → eq=0, gt=1, lt=0, `flags_valid = 1`.
  - 2 → eq=0, gt=0, lt=1, `flags_valid = 1`.
  - Any other value → eq=gt=lt=0, `flags_valid = 0`.
- Flags hold until the next accepted compare. Non-compare beats never touch them.
- Store beats (`alu_op == 3'b100`, `mem_write = 1`) pass through unchanged. No arithmetic is performed in this stage; all fields are carried bit-exact.

## Timing
- Reset (async, `rst_n = 0`):
  - State is EMPTY.
  - All data registers and all outputs are 0, except `in_ready = 1`.
- Latency: a beat accepted in cycle N is on the outputs with `out_valid = 1` in cycle N+1.
- Throughput: one beat per cycle while `out_ready = 1`.
- `in_ready` is a function of registered state only. There is no combinational path from `out_ready` to `in_ready`.
- Back-pressure: after `out_ready` drops, at most one further beat is absorbed (into the skid), then `in_ready = 0` from the next cycle.
- Flags are visible the cycle after the compare is accepted.
- Reset asserted mid-operation empties the stage immediately; buffered beats are lost.

## Configuration
- `EXMEM_FWD_EN` defined:
  - `fwd_valid = out_valid & out_reg_write & !out_mem_to_reg`.
  - `fwd_rd = out_rd_addr`, `fwd_data = out_alu_result`.
  - All three are combinational from the main register.
- `EXMEM_FWD_EN` undefined: `fwd_valid`, `fwd_rd` and `fwd_data` are tied to 0. Ports remain present.

## Structure
- `exmem_pkg` contains:
  - ALU op constants `ALU_SUB=3'b000`, `ALU_ADD=3'b001`, `ALU_LSL=3'b010`, `ALU_NEG=3'b011`, `ALU_STR=3'b100`, `ALU_CMP=3'b101`.
  - Compare codes `CMP_EQ=0`, `CMP_GT=1`, `CMP_LT=2`.
  - The state enum and a packed payload struct.
- One sub-module, `skid_buffer`, is parameterised on payload width and holds the EMPTY/HALF/FULL FSM. The flag register and forwarding logic live in `ex_mem_stage`.

## Test plan
- Reset → `in_ready = 1`, `out_valid = 0`, flags 0. Single ADD beat `alu_result = 16'h0012`, `rd = 3`, `reg_write = 1` → next cycle `out_valid = 1`, `out_alu_result = 16'h0012`, `out_rd_addr = 3`.
- Stream 8 beats (results 1..8) with `out_ready = 1` → 8 consecutive outputs in order, one per cycle, no bubbles.
- `out_ready = 0` while streaming → two beats held, `in_ready = 0`. Raise `out_ready` → beats retire in order, none lost or duplicated.
- Compare beats with `alu_result` 1, then 2, then 7 → flags gt; then lt; then all 0 with `flags_valid = 0`. An ADD beat in between leaves flags unchanged.
- FULL state plus `flush = 1` with `in_valid = 1` → next cycle EMPTY, `out_valid = 0`, offered beat not output, flags unchanged.
- `EXMEM_FWD_EN` defined, head beat `reg_write = 1`, `mem_to_reg = 0`, `rd = 5`, result `16'hBEEF` → `fwd_valid = 1`, `fwd_rd = 5`, `fwd_data = 16'hBEEF`. Same beat with `mem_to_reg = 1` → `fwd_valid = 0`.

Source files
------------

// File: rtl/exmem_pkg.sv
// EX/MEM stage shared types: ALU op codes, compare codes,
// skid-buffer state enum and the EX->MEM payload bundle.
package exmem_pkg;

  localparam logic [2:0] ALU_SUB = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_LSL = 3'b010;
  localparam logic [2:0] ALU_NEG = 3'b011;
  localparam logic [2:0] ALU_STR = 3'b100;
  localparam logic [2:0] ALU_CMP = 3'b101;

  localparam int CMP_EQ = 0;
  localparam int CMP_GT = 1;
  localparam int CMP_LT = 2;

  localparam int XLEN = 16;
  localparam int RLEN = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } sb_state_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [RLEN-1:0] rd_addr;
    logic            reg_write;
    logic            mem_write;
    logic            mem_to_reg;
  } ex_mem_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: main (head) + skid register, EMPTY/HALF/FULL FSM.
// Ports: in_valid/in_ready/in_data, out_valid/out_ready/out_data, flush.
module skid_buffer
  import exmem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  sb_state_t    state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         acc, ret;

  // in_ready depends on registered state only
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;

  assign acc = in_valid & in_ready & ~flush;
  assign ret = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d = ST_HALF;
          main_d  = in_data;
        end
      end
      ST_HALF: begin
        if (acc && ret) begin
          main_d = in_data;
        end else if (acc) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (ret) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (ret) begin
          state_d = ST_HALF;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM hand-off: skid-buffered ALU beat, sticky compare flags,
// optional EX->EX forwarding port (enable with EXMEM_FWD_EN).
module ex_mem_stage
  import exmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  rd_addr,
  input  logic              reg_write,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_rd_addr,
  output logic              out_reg_write,
  output logic              out_mem_write,
  output logic              out_mem_to_reg,
  output logic              flag_eq,
  output logic              flag_gt,
  output logic              flag_lt,
  output logic              flags_valid,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int PW = 2*DATA_W + REG_W + 3;

  logic [PW-1:0] in_pl, out_pl;
  logic          acc;
  logic          is_eq, is_gt, is_lt;

  assign in_pl = {alu_result, store_data, rd_addr,
                  reg_write, mem_write, mem_to_reg};

  skid_buffer #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  assign {out_alu_result, out_store_data, out_rd_addr,
          out_reg_write, out_mem_write, out_mem_to_reg} = out_pl;

  assign acc   = in_valid & in_ready & ~flush;
  assign is_eq = (alu_result == DATA_W'(CMP_EQ));
  assign is_gt = (alu_result == DATA_W'(CMP_GT));
  assign is_lt = (alu_result == DATA_W'(CMP_LT));

  // Sticky: only an accepted compare beat rewrites the flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_eq     <= 1'b0;
      flag_gt     <= 1'b0;
      flag_lt     <= 1'b0;
      flags_valid <= 1'b0;
    end else if (acc && alu_op == ALU_CMP) begin
      flag_eq     <= 1'b0;
      flag_gt     <= 1'b0;
      flag_lt     <= 1'b0;
      flags_valid <= 1'b1;
      unique case (1'b1)
        is_eq:   flag_eq <= 1'b1;
        is_gt:   flag_gt <= 1'b1;
        is_lt:   flag_lt <= 1'b1;
        default: flags_valid <= 1'b0;
      endcase
    end
  end

`ifdef EXMEM_FWD_EN
  assign fwd_valid = out_valid & out_reg_write & ~out_mem_to_reg;
  assign fwd_rd    = out_rd_addr;
  assign fwd_data  = out_alu_result;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule
